// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: per-channel synchronizer, debouncer and press/release
// strobe generator for active-low board keys.
// Optional auto-repeat is compiled in when the macro KEY_AUTO_REPEAT_EN is
// defined. In that build, a held key emits additional press_pulse strobes:
// the first after repeat_delay cycles, then one every repeat_period cycles.
// Without the macro, press_pulse fires once per accepted press and the repeat
// parameters are only range-checked.
// No valid/ready handshake: outputs are plain registered levels and
// one-cycle strobes, valid every cycle.
module key_debounce_pulse #(
  parameter int w              = 2,
  parameter int debounce_depth = 16,
  parameter int repeat_delay   = 25000000,
  parameter int repeat_period  = 5000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] key_n,
  output logic [w-1:0] pressed,
  output logic [w-1:0] press_pulse,
  output logic [w-1:0] release_pulse
);

  localparam int cw = $clog2(debounce_depth + 1);
  localparam logic [cw-1:0] cnt_last = cw'(debounce_depth - 1);

`ifdef KEY_AUTO_REPEAT_EN
  localparam int rep_max = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
  localparam int rw = $clog2(rep_max + 1);
  localparam logic [rw-1:0] delay_last  = rw'(repeat_delay - 1);
  localparam logic [rw-1:0] period_last = rw'(repeat_period - 1);
`endif

  // Parameter legality is checked at elaboration time.
  if (debounce_depth < 1 || debounce_depth > (1 << 20)) begin : g_bad_depth
    $error("key_debounce_pulse: debounce_depth out of range");
  end
  if (repeat_delay < 1 || repeat_period < 1) begin : g_bad_repeat
    $error("key_debounce_pulse: repeat_delay and repeat_period must be >= 1");
  end

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_hold = 2'd1
`ifdef KEY_AUTO_REPEAT_EN
    , st_repeat = 2'd2
`endif
  } state_t;

  for (genvar i = 0; i < w; i++) begin : g_ch
    logic          sync_a;
    logic          sync_b;
    logic [cw-1:0] cnt;
    logic          level;
    logic          acc_press;
    logic          acc_release;
    state_t        state;
    state_t        state_nxt;
    logic          pp_q;
    logic          pp_nxt;
    logic          rp_q;
    logic          rp_nxt;
`ifdef KEY_AUTO_REPEAT_EN
    logic [rw-1:0] rcnt;
    logic [rw-1:0] rcnt_nxt;
`endif

    // Two-flop synchronizer; inversion makes 1 mean "held", reset = released.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
      end else begin
        sync_a <= ~key_n[i];
        sync_b <= sync_a;
      end
    end

    // The edge that toggles the debounced level; the counter never exceeds cnt_last.
    assign acc_press   = sync_b & ~level & (cnt == cnt_last);
    assign acc_release = ~sync_b & level & (cnt == cnt_last);

    // Stability counter: toggle the level after debounce_depth differing edges.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == cnt_last) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + cw'(1);
      end
    end

    // FSM and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= st_idle;
        pp_q  <= 1'b0;
        rp_q  <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        rcnt  <= '0;
`endif
      end else begin
        state <= state_nxt;
        pp_q  <= pp_nxt;
        rp_q  <= rp_nxt;
`ifdef KEY_AUTO_REPEAT_EN
        rcnt  <= rcnt_nxt;
`endif
      end
    end

    // Next state and strobes; an accepted release always beats a due repeat.
    always_comb begin
      state_nxt = state;
      pp_nxt    = 1'b0;
      rp_nxt    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rcnt_nxt  = rcnt;
`endif
      case (state)
        st_idle: begin
          if (acc_press) begin
            state_nxt = st_hold;
            pp_nxt    = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt_nxt  = '0;
`endif
          end
        end
        st_hold: begin
          if (acc_release) begin
            state_nxt = st_idle;
            rp_nxt    = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt_nxt  = '0;
          end else if (rcnt == delay_last) begin
            state_nxt = st_repeat;
            pp_nxt    = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt  = rcnt + rw'(1);
`endif
          end
        end
`ifdef KEY_AUTO_REPEAT_EN
        st_repeat: begin
          if (acc_release) begin
            state_nxt = st_idle;
            rp_nxt    = 1'b1;
            rcnt_nxt  = '0;
          end else if (rcnt == period_last) begin
            pp_nxt    = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt  = rcnt + rw'(1);
          end
        end
`endif
        default: begin
          state_nxt = st_idle;
        end
      endcase
    end

    assign pressed[i]       = level;
    assign press_pulse[i]   = pp_q;
    assign release_pulse[i] = rp_q;
  end

endmodule

// File: doc/key_debounce_pulse.md
KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 Parameter: w, 2, number of independent key channels.
REQ-002 Parameter: debounce_depth, 16, consecutive clock cycles a new synchronized value must hold before it is accepted (legal range 1 to 2^20).
REQ-003 Parameter: repeat_delay, 25000000, cycles from an accepted press to the first auto-repeat pulse (legal range >= 1).
REQ-004 Parameter: repeat_period, 5000000, cycles between subsequent auto-repeat pulses (legal range >= 1).
REQ-005 Port: clk  input  1  system clock, 50 MHz on the board.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: key_n  input  w  raw board keys, active-low, asynchronous to clk.
REQ-008 Port: pressed  output  w  debounced key level, 1 = held.
REQ-009 Port: press_pulse  output  w  one-cycle strobe on each accepted press, and on each auto-repeat when enabled.
REQ-010 Port: release_pulse  output  w  one-cycle strobe on each accepted release.

Function
REQ-011 Each channel shall be fully independent; all requirements below apply per bit.
REQ-012 key_n shall pass through a 2-flop synchronizer, inverted so that sync = 1 means held.
REQ-013 A stability counter shall clear on every edge where sync equals pressed, and increment where it differs.
REQ-014 The counter width shall be $clog2(debounce_depth + 1); it shall never wrap.
REQ-015 When sync has differed from pressed on debounce_depth consecutive edges, pressed shall toggle on that edge and the counter shall clear.
REQ-016 Total latency from a clean raw edge to pressed changing shall be 2 + debounce_depth clock edges.
REQ-017 A glitch shorter than debounce_depth synchronized cycles shall leave pressed and both pulse outputs unchanged.
REQ-018 press_pulse shall be high exactly in the cycle in which pressed is first 1; release_pulse exactly in the cycle in which pressed is first 0.
REQ-019 All outputs shall be registered; no combinational path from key_n to any output.
REQ-020 Per-channel FSM states: IDLE (pressed 0), HOLD, REPEAT.
REQ-021 Accepted press: IDLE to HOLD with the repeat counter at 0. Accepted release from HOLD or REPEAT: to IDLE, counter cleared, release_pulse asserted.
REQ-022 In HOLD, after repeat_delay cycles with pressed still 1: press_pulse for one cycle, transition to REPEAT, counter cleared.
REQ-023 In REPEAT: press_pulse every repeat_period cycles while pressed stays 1.
REQ-024 If a release is accepted on the same edge a repeat would fire, the release shall win; no press_pulse is issued in that cycle.
REQ-025 press_pulse and release_pulse shall never be high in the same cycle on the same channel.

Reset
REQ-026 Asserting rst_n low shall immediately force: synchronizer flops to the released value, counters to 0, FSMs to IDLE, and pressed, press_pulse and release_pulse to 0.
REQ-027 Reset asserted mid-debounce or mid-repeat shall discard all progress.
REQ-028 After rst_n rises, a key already held shall produce a normal press after 2 + debounce_depth edges.
REQ-029 Reset deassertion is assumed synchronized externally; no internal synchronizer is required.

Configuration
REQ-030 Macro KEY_AUTO_REPEAT_EN: when defined, HOLD/REPEAT behaviour per REQ-022 to REQ-024 is compiled in.
REQ-031 When KEY_AUTO_REPEAT_EN is undefined: repeat counters and the REPEAT state shall not be synthesized, repeat_delay and repeat_period shall be ignored, and press_pulse shall fire only once per accepted press.

Verification
REQ-032 Settings debounce_depth=4, w=2: key_n[0] falls and stays low -> pressed[0] rises on edge 6 after the change, press_pulse[0] is high one cycle, and channel 1 is unchanged.
REQ-033 Settings debounce_depth=4: key_n[1] pulses low for 3 cycles -> pressed, press_pulse and release_pulse all stay 0.
REQ-034 Settings KEY_AUTO_REPEAT_EN, debounce_depth=2, repeat_delay=10, repeat_period=3: hold for 30 cycles -> press pulses at acceptance, at +10 cycles, then every 3 cycles; release -> exactly one release_pulse with no trailing press_pulse.
REQ-035 Settings as REQ-034: release accepted on the same edge a repeat is due -> release_pulse=1 and press_pulse=0 in that cycle.
REQ-036 rst_n is driven low while a key is held in REPEAT -> all outputs go 0 immediately; rst_n is released with the key still held -> a fresh press_pulse after 2 + debounce_depth edges.
REQ-037 Random key_n with 100000 cycles at debounce_depth=1 -> the bench checks REQ-025 and checks that the pulses match edges of pressed on every cycle.
